// File: rtl/uart_frac_baud_gen.sv
// Fractional baud-rate generator: 16x oversampling tick plus bit-rate tick for the APB UART.
// Define UART_BAUD_FRAC_EN to enable the eighth-step fractional accumulator.
module uart_frac_baud_gen (
  input  logic        PCLK,
  input  logic        aresetn,
  input  logic        baud_en,
  input  logic [12:0] baud_val,
  input  logic [2:0]  baud_val_fraction,
  output logic        baud_tick,
  output logic        xmit_tick
);

  logic [13:0] cnt_r;
  logic [3:0]  xcnt_r;
  logic        carry_s;
  logic [13:0] load_s;
  logic        reload_s;

`ifdef UART_BAUD_FRAC_EN
  logic [2:0] acc_r;
  logic [2:0] acc_nxt_s;

  // Fraction sum: overflow of the eighths accumulator stretches the next period by one cycle.
  always_comb begin
    {carry_s, acc_nxt_s} = {1'b0, acc_r} + {1'b0, baud_val_fraction};
  end

  // Accumulator advances only at reloads and forgets everything while idle.
  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      acc_r <= 3'd0;
    end else if (!baud_en) begin
      acc_r <= 3'd0;
    end else if (reload_s) begin
      acc_r <= acc_nxt_s;
    end else begin
      acc_r <= acc_r;
    end
  end
`else
  logic unused_fraction_s;

  assign carry_s           = 1'b0;
  assign unused_fraction_s = ^baud_val_fraction;
`endif

  assign reload_s = (cnt_r == 14'd0);
  // 14 bits so baud_val=8191 plus a carry loads 8192 without wrapping.
  assign load_s   = {1'b0, baud_val} + {13'd0, carry_s};

  // Period counter, tick counter and registered strobes.
  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      cnt_r     <= 14'd0;
      xcnt_r    <= 4'd0;
      baud_tick <= 1'b0;
      xmit_tick <= 1'b0;
    end else if (!baud_en) begin
      cnt_r     <= 14'd0;
      xcnt_r    <= 4'd0;
      baud_tick <= 1'b0;
      xmit_tick <= 1'b0;
    end else if (reload_s) begin
      cnt_r     <= load_s;
      xcnt_r    <= xcnt_r + 4'd1;
      baud_tick <= 1'b1;
      xmit_tick <= (xcnt_r == 4'd15);
    end else begin
      cnt_r     <= cnt_r - 14'd1;
      xcnt_r    <= xcnt_r;
      baud_tick <= 1'b0;
      xmit_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Self-checking bench for uart_frac_baud_gen: directed and random runs against a closed-form tick schedule.
module tb_uart_frac_baud_gen;

  logic        PCLK;
  logic        aresetn;
  logic        baud_en;
  logic [12:0] baud_val;
  logic [2:0]  baud_val_fraction;
  logic        baud_tick;
  logic        xmit_tick;

  int checks;
  int failures;

  uart_frac_baud_gen dut (
    .PCLK              (PCLK),
    .aresetn           (aresetn),
    .baud_en           (baud_en),
    .baud_val          (baud_val),
    .baud_val_fraction (baud_val_fraction),
    .baud_tick         (baud_tick),
    .xmit_tick         (xmit_tick)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  // Effective fraction seen by the design in this build.
  function automatic int eff_frac(input int f);
`ifdef UART_BAUD_FRAC_EN
    return f;
`else
    return 0;
`endif
  endfunction

  // Tick n (counting from 0) lands n*(bv+1) + floor(n*f/8) cycles after the first one.
  function automatic int tick_time(input int n, input int bv, input int f);
    return n * (bv + 1) + (n * eff_frac(f)) / 8;
  endfunction

  // Enable the generator with a fixed setting and compare both strobes every cycle.
  task automatic run_check(input string tag, input int bv, input int f, input int ncyc);
    int  n_next;
    logic exp_b;
    logic exp_x;
    baud_val          = 13'(bv);
    baud_val_fraction = 3'(f);
    baud_en           = 1'b1;
    n_next            = 0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      exp_b = 1'b0;
      exp_x = 1'b0;
      if (c == tick_time(n_next, bv, f)) begin
        exp_b = 1'b1;
        exp_x = ((n_next % 16) == 15);
        n_next++;
      end
      chk({tag, "_baud"}, c, baud_tick, exp_b);
      chk({tag, "_xmit"}, c, xmit_tick, exp_x);
    end
  endtask

  task automatic idle_check(input string tag);
    baud_en = 1'b0;
    step();
    chk({tag, "_idle_baud"}, 0, baud_tick, 1'b0);
    chk({tag, "_idle_xmit"}, 0, xmit_tick, 1'b0);
    step();
    chk({tag, "_idle2_baud"}, 1, baud_tick, 1'b0);
  endtask

  initial begin
    int   rbv;
    int   rf;
    logic exp_b;
    checks            = 0;
    failures          = 0;
    aresetn           = 1'b0;
    baud_en           = 1'b0;
    baud_val          = 13'd0;
    baud_val_fraction = 3'd0;
    step();
    step();
    chk("reset_baud", 0, baud_tick, 1'b0);
    chk("reset_xmit", 0, xmit_tick, 1'b0);
    aresetn = 1'b1;
    step();
    chk("post_reset_baud", 0, baud_tick, 1'b0);

    // Every-cycle ticks, xmit once per 16.
    run_check("bv0", 0, 0, 40);
    idle_check("bv0");
    // Period 4, xmit period 64.
    run_check("bv3", 3, 0, 140);
    idle_check("bv3");
    // Alternating 4,5 when the fraction is enabled.
    run_check("bv3f4", 3, 4, 80);
    idle_check("bv3f4");
    // Seven periods of 10 then one of 11.
    run_check("bv9f1", 9, 1, 200);
    idle_check("bv9f1");
    // Fraction 7 with the largest carry density.
    run_check("bv1f7", 1, 7, 60);
    idle_check("bv1f7");

    for (int i = 0; i < 4; i++) begin
      rbv = int'($urandom_range(12, 0));
      rf  = int'($urandom_range(7, 0));
      run_check("rand", rbv, rf, 150);
      idle_check("rand");
    end

    // Divisor change two cycles after a reload only affects the following period.
    baud_val          = 13'd3;
    baud_val_fraction = 3'd0;
    baud_en           = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (c == 2) baud_val = 13'd7;
      exp_b = (c == 0) || (c == 4) || ((c > 4) && (((c - 4) % 8) == 0));
      chk("midchg_baud", c, baud_tick, exp_b);
    end
    idle_check("midchg");

    // Disable mid-period with xcnt=9, then restart from scratch.
    run_check("abort_en_pre", 2, 0, 26);
    idle_check("abort_en");
    run_check("abort_en_post", 2, 0, 60);

    // Asynchronous reset mid-period with xcnt=9, then restart from scratch.
    idle_check("pre_rst");
    run_check("abort_rst_pre", 2, 0, 26);
    aresetn = 1'b0;
    #1;
    chk("async_rst_baud", 0, baud_tick, 1'b0);
    chk("async_rst_xmit", 0, xmit_tick, 1'b0);
    baud_en = 1'b0;
    step();
    aresetn = 1'b1;
    step();
    chk("rst_release_baud", 0, baud_tick, 1'b0);
    chk("rst_release_xmit", 0, xmit_tick, 1'b0);
    run_check("abort_rst_post", 2, 0, 60);
    idle_check("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
